// File: rtl/udma_apb_req_arbiter.sv
// udma_apb_req_arbiter
//
// Shares a single APB master port between N_REQ register-access requesters
// (core, debug, DMA config paths, ...). Requesters are served round-robin and
// only one APB transfer is in flight at a time. A transfer runs through the
// usual SETUP/ACCESS sequence. PREADY can stretch it with wait states. A
// timeout aborts it with an error when the slave never answers.
//
// Ports:
//   clk_i, rstn_i   clock, synchronous active-low reset
//   req_valid_i     per-requester request valid
//   req_ready_o     one-hot grant pulse (combinational, IDLE only)
//   req_addr_i      packed addresses, requester i at [i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]
//   req_wdata_i     packed write data, requester i at [i*32 +: 32]
//   req_we_i        per-requester direction, 1 = write
//   rsp_valid_o     one-hot response pulse to the requester that owned the transfer
//   rsp_rdata_o     read data (0 for writes and timeouts), valid with rsp_valid_o
//   rsp_err_o       PSLVERR or timeout, valid with rsp_valid_o
//   PADDR, PWDATA, PWRITE, PSEL, PENABLE, PRDATA, PREADY, PSLVERR
//                   APB master port towards the uDMA peripheral decoder
module udma_apb_req_arbiter #(
  parameter int N_REQ          = 4,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_CNT_WIDTH   = 8
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic [N_REQ-1:0]                req_valid_i,
  output logic [N_REQ-1:0]                req_ready_o,
  input  logic [N_REQ*APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [N_REQ*32-1:0]             req_wdata_i,
  input  logic [N_REQ-1:0]                req_we_i,
  output logic [N_REQ-1:0]                rsp_valid_o,
  output logic [31:0]                     rsp_rdata_o,
  output logic                            rsp_err_o,
  output logic [APB_ADDR_WIDTH-1:0]       PADDR,
  output logic [31:0]                     PWDATA,
  output logic                            PWRITE,
  output logic                            PSEL,
  output logic                            PENABLE,
  input  logic [31:0]                     PRDATA,
  input  logic                            PREADY,
  input  logic                            PSLVERR
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Counter value on the last ACCESS cycle that may still end normally.
  localparam logic [TO_CNT_WIDTH-1:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        next_ptr;
  logic [TO_CNT_WIDTH-1:0] to_cnt;
  logic [N_REQ-1:0]        owner;

  logic                      found;
  logic [PTR_W-1:0]          winner;
  logic [N_REQ-1:0]          cand;
  logic [APB_ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]               sel_wdata;
  logic                      sel_we;

  logic take;
  logic done;
  logic abort;
  logic timeout_hit;

  // Round-robin search: scan requesters starting at rr_ptr and wrap around.
  // The winner's one-hot mask and request fields are selected here so that
  // the IDLE state can grant and latch them in the same cycle.
  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    winner    = '0;
    cand      = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!found && req_valid_i[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (found && (winner == PTR_W'(i))) begin
        cand[i]   = 1'b1;
        sel_addr  = req_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
        sel_wdata = req_wdata_i[i*32 +: 32];
        sel_we    = req_we_i[i];
      end
    end
  end

  // Wraparound is explicit because N_REQ need not be a power of two.
  assign next_ptr = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + PTR_W'(1);

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);

  // Next-state logic. PREADY is tested first so a slave answering on the
  // timeout cycle still completes normally with its own PSLVERR.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          take    = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The grant is masked while reset is asserted: the edge will not accept it.
  assign req_ready_o = (take && rstn_i) ? cand : '0;
  assign PSEL        = (state_q != IDLE);
  assign PENABLE     = (state_q == ACCESS);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: latch the winning request on grant and keep it on the bus
  // until the next grant. The response registers hold data for exactly one
  // cycle, so the response pulse coincides with the FSM being back in IDLE.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rr_ptr      <= '0;
      to_cnt      <= '0;
      owner       <= '0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;

      if (take) begin
        PADDR  <= sel_addr;
        PWDATA <= sel_wdata;
        PWRITE <= sel_we;
        owner  <= cand;
        rr_ptr <= next_ptr;
      end

      if (state_q == SETUP) begin
        to_cnt <= '0;
      end else if ((state_q == ACCESS) && !PREADY) begin
        to_cnt <= to_cnt + TO_CNT_WIDTH'(1);
      end

      if (done) begin
        rsp_valid_o <= owner;
        rsp_rdata_o <= PWRITE ? 32'h0 : PRDATA;
        rsp_err_o   <= PSLVERR;
      end else if (abort) begin
        rsp_valid_o <= owner;
        rsp_err_o   <= 1'b1;
      end
    end
  end

endmodule
